// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: the pipeline write-back has priority, and
// MDU results are buffered in a FIFO and written in idle slots or when starved.
module wb_port_arbiter #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAX_WAIT = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_wb_en,
    input  logic [ADDR_W-1:0]          pipe_wb_addr,
    input  logic [DATA_W-1:0]          pipe_wb_data,
    output logic                       pipe_stall,
    input  logic                       mdu_valid,
    input  logic [ADDR_W-1:0]          mdu_addr,
    input  logic [DATA_W-1:0]          mdu_data,
    output logic                       mdu_ready,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_waddr,
    output logic [DATA_W-1:0]          rf_wdata,
    output logic [$clog2(DEPTH):0]     mdu_pending
);

    localparam int unsigned PTR_W  = $clog2(DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
    logic [DATA_W-1:0] fifo_data_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

    logic              not_empty;
    logic              starve;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;

    // Everything that gates a push or a pop comes from registers, so a result
    // pushed into an empty FIFO can only pop on a later cycle.
    always_comb begin
        not_empty = (count_q != '0);
        starve    = not_empty && (wait_cnt_q == WAIT_W'(MAX_WAIT));
        mdu_ready = (count_q < CNT_W'(DEPTH));
        push      = mdu_valid && mdu_ready;
        pop       = starve || (!pipe_wb_en && not_empty);
        head_addr = fifo_addr_q[rd_ptr_q];
        head_data = fifo_data_q[rd_ptr_q];
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        wait_cnt_d = wait_cnt_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (pop || !not_empty) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end

        // A write to r0 still consumes its slot; only the enable is dropped.
        if (pop) begin
            rf_we_d    = (head_addr != '0);
            rf_waddr_d = head_addr;
            rf_wdata_d = head_data;
        end else if (pipe_wb_en) begin
            rf_we_d    = (pipe_wb_addr != '0);
            rf_waddr_d = pipe_wb_addr;
            rf_wdata_d = pipe_wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            wait_cnt_q <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            wait_cnt_q <= wait_cnt_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= mdu_addr;
            fifo_data_q[wr_ptr_q] <= mdu_data;
        end
    end

    assign pipe_stall  = starve;
    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign mdu_pending = count_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: a vector table for single-cycle behaviour
// plus hand-written starvation, full-FIFO and mid-burst reset sequences.
module tb_wb_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        pipe_wb_en;
    logic [4:0]  pipe_wb_addr;
    logic [31:0] pipe_wb_data;
    logic        pipe_stall;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [2:0]  mdu_pending;

    int checks = 0;
    int errors = 0;

    wb_port_arbiter #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .DEPTH    (4),
        .MAX_WAIT (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pipe_wb_en   (pipe_wb_en),
        .pipe_wb_addr (pipe_wb_addr),
        .pipe_wb_data (pipe_wb_data),
        .pipe_stall   (pipe_stall),
        .mdu_valid    (mdu_valid),
        .mdu_addr     (mdu_addr),
        .mdu_data     (mdu_data),
        .mdu_ready    (mdu_ready),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .mdu_pending  (mdu_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        pe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [2:0]  pend;
        logic        stall;
        logic        rdy;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        pipe_wb_en   = 1'b0;
        pipe_wb_addr = '0;
        pipe_wb_data = '0;
        mdu_valid    = 1'b0;
        mdu_addr     = '0;
        mdu_data     = '0;
    endtask

    int sent;
    int got;
    int first_reject;
    int stall_cycles;
    int consec;
    logic prev_stall;
    logic accepted;

    initial begin
        // Expected values are the registered outputs just after the edge that
        // consumes the listed inputs.
        //           pe  pa  pd            mv  ma   md            we  wa   wd            pend stall rdy
        vecs[0]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h0,        0, 0, 1};
        vecs[1]  = '{0, 0,  32'h0,        1, 7,  32'hDEADBEEF, 0, 0,  32'h0,        1, 0, 1};
        vecs[2]  = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 7,  32'hDEADBEEF, 0, 0, 1};
        vecs[3]  = '{1, 5,  32'h55,       0, 0,  32'h0,        1, 5,  32'h55,       0, 0, 1};
        vecs[4]  = '{1, 0,  32'h1234,     0, 0,  32'h0,        0, 0,  32'h1234,     0, 0, 1};
        vecs[5]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'h1234,     0, 0, 1};
        vecs[6]  = '{1, 4,  32'h44,       1, 0,  32'hAAAA,     1, 4,  32'h44,       1, 0, 1};
        vecs[7]  = '{0, 0,  32'h0,        0, 0,  32'h0,        0, 0,  32'hAAAA,     0, 0, 1};
        vecs[8]  = '{1, 6,  32'h66,       1, 10, 32'h100,      1, 6,  32'h66,       1, 0, 1};
        vecs[9]  = '{1, 6,  32'h67,       1, 11, 32'h101,      1, 6,  32'h67,       2, 0, 1};
        vecs[10] = '{0, 0,  32'h0,        1, 12, 32'h102,      1, 10, 32'h100,      2, 0, 1};
        vecs[11] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 11, 32'h101,      1, 0, 1};
        vecs[12] = '{0, 0,  32'h0,        0, 0,  32'h0,        1, 12, 32'h102,      0, 0, 1};

        rst_n = 1'b0;
        idle_inputs();
        #12;
        chk("reset_rf_we",    32'(rf_we),       32'd0);
        chk("reset_waddr",    32'(rf_waddr),    32'd0);
        chk("reset_wdata",    rf_wdata,         32'd0);
        chk("reset_pending",  32'(mdu_pending), 32'd0);
        chk("reset_stall",    32'(pipe_stall),  32'd0);
        chk("reset_ready",    32'(mdu_ready),   32'd1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) begin
            pipe_wb_en   = vecs[i].pe;
            pipe_wb_addr = vecs[i].pa;
            pipe_wb_data = vecs[i].pd;
            mdu_valid    = vecs[i].mv;
            mdu_addr     = vecs[i].ma;
            mdu_data     = vecs[i].md;
            step();
            chk($sformatf("v%0d_rf_we", i),   32'(rf_we),       32'(vecs[i].we));
            chk($sformatf("v%0d_waddr", i),   32'(rf_waddr),    32'(vecs[i].wa));
            chk($sformatf("v%0d_wdata", i),   rf_wdata,         vecs[i].wd);
            chk($sformatf("v%0d_pending", i), 32'(mdu_pending), 32'(vecs[i].pend));
            chk($sformatf("v%0d_stall", i),   32'(pipe_stall),  32'(vecs[i].stall));
            chk($sformatf("v%0d_ready", i),   32'(mdu_ready),   32'(vecs[i].rdy));
        end
        idle_inputs();
        step();

        // Starvation: pipeline writes r3 every cycle, one MDU push to r9.
        stall_cycles = 0;
        for (int c = 0; c < 6; c++) begin
            pipe_wb_en   = 1'b1;
            pipe_wb_addr = 5'd3;
            pipe_wb_data = 32'(c);
            mdu_valid    = (c == 0);
            mdu_addr     = 5'd9;
            mdu_data     = 32'h999;
            step();
            if (pipe_stall) stall_cycles++;
            chk($sformatf("starve_c%0d_stall", c), 32'(pipe_stall), (c == 3) ? 32'd1 : 32'd0);
            chk($sformatf("starve_c%0d_waddr", c), 32'(rf_waddr),   (c == 4) ? 32'd9 : 32'd3);
            chk($sformatf("starve_c%0d_we", c),    32'(rf_we),      32'd1);
            if (c == 4) chk("starve_wdata", rf_wdata, 32'h999);
        end
        chk("starve_stall_count", 32'(stall_cycles), 32'd1);
        chk("starve_pending", 32'(mdu_pending), 32'd0);
        idle_inputs();
        step();

        // Full FIFO under a continuously busy pipeline.
        sent = 0;
        got = 0;
        first_reject = -1;
        consec = 0;
        prev_stall = 1'b0;
        for (int c = 0; c < 80 && got < 5; c++) begin
            pipe_wb_en   = 1'b1;
            pipe_wb_addr = 5'd3;
            pipe_wb_data = 32'h333;
            mdu_valid    = (sent < 5);
            mdu_addr     = 5'(20 + sent);
            mdu_data     = 32'hA0 + 32'(sent);
            if (mdu_valid && !mdu_ready && first_reject < 0) first_reject = sent;
            accepted = mdu_valid && mdu_ready;
            step();
            if (accepted) sent++;
            if (rf_we && rf_waddr != 5'd3) begin
                chk($sformatf("full_order_addr%0d", got), 32'(rf_waddr), 32'(20 + got));
                chk($sformatf("full_order_data%0d", got), rf_wdata, 32'hA0 + 32'(got));
                got++;
            end
            if (pipe_stall && prev_stall) consec++;
            prev_stall = pipe_stall;
        end
        chk("full_first_reject_index", 32'(first_reject), 32'd4);
        chk("full_all_accepted", 32'(sent), 32'd5);
        chk("full_all_written", 32'(got), 32'd5);
        chk("full_no_back_to_back_stall", 32'(consec), 32'd0);
        idle_inputs();
        step();
        chk("full_drained_pending", 32'(mdu_pending), 32'd0);

        // Mid-burst reset with three results buffered.
        for (int c = 0; c < 3; c++) begin
            pipe_wb_en   = 1'b1;
            pipe_wb_addr = 5'd2;
            pipe_wb_data = 32'h222;
            mdu_valid    = 1'b1;
            mdu_addr     = 5'(15 + c);
            mdu_data     = 32'hB0 + 32'(c);
            step();
        end
        idle_inputs();
        chk("pre_reset_pending", 32'(mdu_pending), 32'd3);
        chk("pre_reset_rf_we", 32'(rf_we), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_rf_we",   32'(rf_we),       32'd0);
        chk("async_reset_pending", 32'(mdu_pending), 32'd0);
        chk("async_reset_ready",   32'(mdu_ready),   32'd1);
        chk("async_reset_stall",   32'(pipe_stall),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("post_reset_c%0d_rf_we", c), 32'(rf_we), 32'd0);
        end
        chk("post_reset_pending", 32'(mdu_pending), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
